// File: rtl/mmap_m_axi_write_arbiter.sv
// Multi-channel AXI4 write master: round-robin AW arbitration onto one bus,
// W beats forwarded in AW grant order, B responses routed back by BID.

module mmap_m_axi_write_arbiter_ost #(
    parameter int CNT_W = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_nz
);
    logic [CNT_W-1:0] r_cnt;

    // A grant and a response on the same channel in one cycle cancel out.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_inc && !i_dec)
            r_cnt <= r_cnt + CNT_W'(1);
        else if (i_dec && !i_inc)
            r_cnt <= r_cnt - CNT_W'(1);
    end

    assign o_nz = (r_cnt != '0);
endmodule

module mmap_m_axi_write_arbiter #(
    parameter int NUM_CH          = 4,
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int NUM_OUTSTANDING = 8,
    parameter int MAX_BURST_LEN   = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic                           ACLK_EN,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   in_CH_AWADDR,
    input  logic [NUM_CH*8-1:0]            in_CH_AWLEN,
    input  logic [NUM_CH-1:0]              in_CH_AWVALID,
    output logic [NUM_CH-1:0]              out_CH_AWREADY,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_CH_WDATA,
    input  logic [NUM_CH*DATA_WIDTH/8-1:0] in_CH_WSTRB,
    input  logic [NUM_CH-1:0]              in_CH_WLAST,
    input  logic [NUM_CH-1:0]              in_CH_WVALID,
    output logic [NUM_CH-1:0]              out_CH_WREADY,
    output logic [NUM_CH-1:0]              out_CH_BVALID,
    input  logic [NUM_CH-1:0]              in_CH_BREADY,
    output logic [1:0]                     out_CH_BRESP,
    output logic [ID_WIDTH-1:0]            out_BUS_AWID,
    output logic [ADDR_WIDTH-1:0]          out_BUS_AWADDR,
    output logic [7:0]                     out_BUS_AWLEN,
    output logic [2:0]                     out_BUS_AWSIZE,
    output logic [1:0]                     out_BUS_AWBURST,
    output logic [3:0]                     out_BUS_AWCACHE,
    output logic [2:0]                     out_BUS_AWPROT,
    output logic                           out_BUS_AWVALID,
    input  logic                           in_BUS_AWREADY,
    output logic [DATA_WIDTH-1:0]          out_BUS_WDATA,
    output logic [DATA_WIDTH/8-1:0]        out_BUS_WSTRB,
    output logic                           out_BUS_WLAST,
    output logic                           out_BUS_WVALID,
    input  logic                           in_BUS_WREADY,
    input  logic [ID_WIDTH-1:0]            in_BUS_BID,
    input  logic [1:0]                     in_BUS_BRESP,
    input  logic                           in_BUS_BVALID,
    output logic                           out_BUS_BREADY,
    output logic                           out_ERR_BID
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int PTR_W  = $clog2(NUM_OUTSTANDING);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0] OST_MAX = CNT_W'(NUM_OUTSTANDING);

    if (NUM_CH < 2 || NUM_CH > 16 || (1 << ID_WIDTH) < NUM_CH || DATA_WIDTH < 32 ||
        NUM_OUTSTANDING < 2 || MAX_BURST_LEN < 1 || MAX_BURST_LEN > 256) begin : g_bad_cfg
        $error("mmap_m_axi_write_arbiter: unsupported parameter set");
    end

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
    } aw_req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_W-1:0]     strb;
        logic                  last;
    } w_beat_t;

    logic [CH_W-1:0]  r_rr;
    aw_req_t          r_aw;
    logic             r_aw_vld;
    w_beat_t          r_w;
    logic             r_w_vld;
    logic [CNT_W-1:0] r_total;
    logic [CH_W-1:0]  r_fifo [NUM_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_fifo_cnt;
    logic             r_err;

    logic              w_act;
    logic              w_aw_free;
    logic              w_w_free;
    logic              w_fifo_ok;
    logic              w_fifo_ne;
    logic [CH_W-1:0]   w_head;
    logic              w_lo_vld;
    logic              w_hi_vld;
    logic [CH_W-1:0]   w_lo_ch;
    logic [CH_W-1:0]   w_hi_ch;
    logic [CH_W-1:0]   w_gnt_ch;
    logic [CH_W-1:0]   w_rr_nxt;
    logic              w_gnt;
    aw_req_t           w_aw_nxt;
    w_beat_t           w_w_nxt;
    logic              w_sel_vld;
    logic              w_w_rdy;
    logic              w_w_acc;
    logic              w_pop;
    logic [NUM_CH-1:0] w_bid_hit;
    logic [NUM_CH-1:0] w_ost_nz;
    logic [NUM_CH-1:0] w_b_dec;
    logic              w_bid_ok;
    logic              w_sel_bready;
    logic              w_b_hs;
    logic              w_b_bad;

    // Every handshake is gated so nothing is accepted while state is frozen.
    assign w_act     = ACLK_EN && !ARESET;
    assign w_aw_free = !r_aw_vld || in_BUS_AWREADY;
    assign w_w_free  = !r_w_vld || in_BUS_WREADY;
    assign w_fifo_ne = (r_fifo_cnt != '0);
    assign w_head    = r_fifo[r_rd_ptr];

    // Round-robin: lowest requester at or above r_rr, else lowest overall.
    always_comb begin
        w_lo_vld = 1'b0;
        w_hi_vld = 1'b0;
        w_lo_ch  = '0;
        w_hi_ch  = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (in_CH_AWVALID[j]) begin
                w_lo_vld = 1'b1;
                w_lo_ch  = CH_W'(j);
                if (CH_W'(j) >= r_rr) begin
                    w_hi_vld = 1'b1;
                    w_hi_ch  = CH_W'(j);
                end
            end
        end
    end

    assign w_gnt_ch = w_hi_vld ? w_hi_ch : w_lo_ch;
    assign w_rr_nxt = (w_gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_ch + CH_W'(1);
    assign w_gnt    = w_act && w_lo_vld && w_aw_free && w_fifo_ok && (r_total < OST_MAX);

    always_comb begin
        w_aw_nxt    = '0;
        w_aw_nxt.id = ID_WIDTH'(w_gnt_ch);
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt_ch == CH_W'(i)) begin
                w_aw_nxt.addr = in_CH_AWADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_aw_nxt.len  = in_CH_AWLEN[i*8 +: 8];
            end
        end
    end

    always_comb begin
        w_w_nxt   = '0;
        w_sel_vld = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_head == CH_W'(i)) begin
                w_sel_vld    = in_CH_WVALID[i];
                w_w_nxt.data = in_CH_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
                w_w_nxt.strb = in_CH_WSTRB[i*STRB_W +: STRB_W];
                w_w_nxt.last = in_CH_WLAST[i];
            end
        end
    end

    assign w_w_rdy   = w_act && w_fifo_ne && w_w_free;
    assign w_w_acc   = w_w_rdy && w_sel_vld;
    assign w_pop     = w_w_acc && w_w_nxt.last;
    // A full FIFO may still take a push when its head burst completes this cycle.
    assign w_fifo_ok = (r_fifo_cnt != OST_MAX) || w_pop;

    // Unknown or unexpected BIDs are acked on the bus and dropped.
    assign w_bid_ok     = |(w_bid_hit & w_ost_nz);
    assign w_sel_bready = |(w_bid_hit & in_CH_BREADY);
    assign w_b_hs       = w_act && in_BUS_BVALID && w_bid_ok && w_sel_bready;
    assign w_b_bad      = w_act && in_BUS_BVALID && !w_bid_ok;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_bid_hit[i]      = (in_BUS_BID == ID_WIDTH'(i));
        assign w_b_dec[i]        = w_b_hs && w_bid_hit[i];
        assign out_CH_AWREADY[i] = w_gnt && (w_gnt_ch == CH_W'(i));
        assign out_CH_WREADY[i]  = w_w_rdy && (w_head == CH_W'(i));
        assign out_CH_BVALID[i]  = w_act && in_BUS_BVALID && w_bid_hit[i] && w_ost_nz[i];

        mmap_m_axi_write_arbiter_ost #(.CNT_W(CNT_W)) u_ost (
            .i_clk (ACLK),
            .i_rst (ARESET),
            .i_inc (out_CH_AWREADY[i]),
            .i_dec (w_b_dec[i]),
            .o_nz  (w_ost_nz[i])
        );
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rr       <= '0;
            r_aw       <= '0;
            r_aw_vld   <= 1'b0;
            r_w        <= '0;
            r_w_vld    <= 1'b0;
            r_total    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_err      <= 1'b0;
        end else if (ACLK_EN) begin
            if (w_gnt) begin
                r_aw_vld <= 1'b1;
                r_aw     <= w_aw_nxt;
                r_rr     <= w_rr_nxt;
            end else if (in_BUS_AWREADY) begin
                r_aw_vld <= 1'b0;
            end

            if (w_w_acc) begin
                r_w_vld <= 1'b1;
                r_w     <= w_w_nxt;
            end else if (in_BUS_WREADY) begin
                r_w_vld <= 1'b0;
            end

            if (w_gnt)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_gnt && !w_pop)
                r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
            else if (w_pop && !w_gnt)
                r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);

            if (w_gnt && !w_b_hs)
                r_total <= r_total + CNT_W'(1);
            else if (w_b_hs && !w_gnt)
                r_total <= r_total - CNT_W'(1);

            if (w_b_bad)
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_gnt)
            r_fifo[r_wr_ptr] <= w_gnt_ch;
    end

    assign out_BUS_AWID    = r_aw.id;
    assign out_BUS_AWADDR  = r_aw.addr;
    assign out_BUS_AWLEN   = r_aw.len;
    assign out_BUS_AWVALID = r_aw_vld;
    assign out_BUS_AWSIZE  = 3'($clog2(STRB_W));
    assign out_BUS_AWBURST = 2'b01;
    assign out_BUS_AWCACHE = 4'b0011;
    assign out_BUS_AWPROT  = 3'b000;
    assign out_BUS_WDATA   = r_w.data;
    assign out_BUS_WSTRB   = r_w.strb;
    assign out_BUS_WLAST   = r_w.last;
    assign out_BUS_WVALID  = r_w_vld;
    assign out_CH_BRESP    = in_BUS_BRESP;
    assign out_BUS_BREADY  = w_act && (w_bid_ok ? w_sel_bready : in_BUS_BVALID);
    assign out_ERR_BID     = r_err;
endmodule
